// File: rtl/ce_gen_multi.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per
// channel on a shared PLL clock, with a settle counter gating all enables.
module ce_gen_multi #(
    parameter int NUM_CH = 2,
    parameter int ACC_W = 32,
    parameter int LOCK_CYCLES = 16,
    parameter logic [ACC_W-1:0] RESET_STEP = '0,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_step,
    output logic              cfg_ready,
    input  logic              realign,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);

    localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCNT_W-1:0] LOCK_MAX = LCNT_W'(LOCK_CYCLES);

    // Config handshake: a write is taken on an edge where cfg_we and cfg_ready
    // are both high; cfg_ready then drops for exactly the following cycle, and
    // cfg_we seen while cfg_ready is low is discarded without any effect.
    logic accept;
    logic ch_valid;
    logic relock;

    assign accept   = cfg_we & cfg_ready;
    assign ch_valid = int'(cfg_ch) < NUM_CH;
    assign relock   = accept & ch_valid;

    logic [LCNT_W-1:0] lock_cnt;
    logic [LCNT_W-1:0] lock_cnt_nxt;

    always_comb begin
        lock_cnt_nxt = lock_cnt;
        if (relock) begin
            lock_cnt_nxt = '0;
        end else if (lock_cnt != LOCK_MAX) begin
            lock_cnt_nxt = lock_cnt + LCNT_W'(1);
        end
    end

    // locked follows the next count so it rises on the LOCK_CYCLES-th edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_cnt  <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            lock_cnt  <= lock_cnt_nxt;
            locked    <= (lock_cnt_nxt == LOCK_MAX);
            cfg_ready <= ~accept;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [ACC_W-1:0] step_r;
        logic [ACC_W-1:0] acc_r;
        logic [ACC_W:0]   sum;
        logic             hit;
        logic             ce_r;

        assign hit = relock && (int'(cfg_ch) == k);
        assign sum = {1'b0, acc_r} + {1'b0, step_r};

        // Clearing acc on retune keeps the first interval after relock exact.
        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                step_r <= RESET_STEP;
                acc_r  <= '0;
                ce_r   <= 1'b0;
            end else begin
                if (hit) begin
                    step_r <= cfg_step;
                end
                if (realign || hit || !locked) begin
                    acc_r <= '0;
                    ce_r  <= 1'b0;
                end else begin
                    acc_r <= sum[ACC_W-1:0];
                    ce_r  <= sum[ACC_W];
                end
            end
        end

        assign ce[k] = ce_r;
    end

endmodule
